nios2_ocimem_ctrl: RTL

Sysclk-domain consumer of the debug slave's decoded JTAG command stream (jdo plus take_action_ocimem_* strobes). It owns a small on-chip debug RAM and serves two masters: the JTAG monitor, for address load, reads and writes with auto-increment, and the CPU's debug-memory Avalon slave port. It returns MonDReg, monitor_ready and monitor_error to the debug slave for shift-out over JTAG.

---
 rtl/nios2_ocimem_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/nios2_ocimem_ctrl.sv
// nios2_ocimem_ctrl
//   Sysclk-side owner of the on-chip debug RAM. It executes the decoded JTAG
//   monitor commands (address load, read-next, write with auto-increment) and
//   also serves the CPU's debug-memory Avalon slave port. The debug path always
//   wins arbitration. The CPU is stalled while a monitor command is in flight.
//
//   Optional build macro: OCIMEM_WRITE_VERIFY_EN
//     When it is defined, every monitor write is read back (DVR1/DVR2). A
//     mismatch sets monitor_error. monitor_ready rises 4 clk after the strobe.
//
// Ports
//   clk, reset                 system clock, async active-high reset
//   jdo[37:0]                  decoded JTAG word (address/rd_now/clr_err/wdata)
//   take_action_ocimem_a       address load (optionally with an immediate read)
//   take_no_action_ocimem_a    increment the address, then read
//   take_action_ocimem_b       write wdata at MonAReg, then increment
//   MonDReg                    monitor data register returned over JTAG
//   monitor_ready              high = MonDReg valid / controller idle
//   monitor_error              sticky; set when a command collides with a busy FSM
//   avs_*                      CPU Avalon-MM slave; reads take 1 wait state
module nios2_ocimem_ctrl #(
  parameter int ADDR_W     = 8,
  parameter bit INIT_READY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] DRD1 = 3'd1;
  localparam logic [2:0] DRD2 = 3'd2;
  localparam logic [2:0] DWR  = 3'd3;
  localparam logic [2:0] CRD  = 3'd4;
  localparam logic [2:0] DVR1 = 3'd5;
  localparam logic [2:0] DVR2 = 3'd6;

  logic [2:0]        state;
  logic [ADDR_W-1:0] MonAReg;
  logic [31:0]       wdata_q;   // jdo is only valid during the strobe cycle
  logic [31:0]       ram_q;     // registered RAM read port
  logic [31:0]       mem [2**ADDR_W];

  // jdo field decode
  logic [ADDR_W-1:0] j_addr;
  logic              j_rd_now, j_clr_err;
  logic [31:0]       j_wdata;
  assign j_addr    = jdo[17+ADDR_W:18];
  assign j_rd_now  = jdo[17];
  assign j_clr_err = jdo[16];
  assign j_wdata   = jdo[34:3];

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  logic any_strobe, idle;
  assign any_strobe = take_action_ocimem_b | take_action_ocimem_a | take_no_action_ocimem_a;
  assign idle       = (state == IDLE);

  // CPU is served only when idle and no debug command is arriving this cycle.
  logic cpu_ok, cpu_rd, cpu_wr;
  assign cpu_ok = idle & ~any_strobe & ~reset;
  assign cpu_rd = cpu_ok & avs_read;
  assign cpu_wr = cpu_ok & avs_write & ~avs_read;

  // CRD is the read data phase and always completes. A strobe that lands in
  // CRD is dropped by the busy rule and does not cancel the CPU read.
  always_comb begin
    avs_waitrequest = 1'b1;
    if (!reset) begin
      if (state == CRD) avs_waitrequest = 1'b0;
      else              avs_waitrequest = ~idle | any_strobe | avs_read;
    end
  end

  assign avs_readdata = (state == CRD) ? ram_q : 32'h0;

  // RAM write port: the debug write in DWR, or a CPU write in IDLE. Both are
  // gated by reset so that a write in flight is abandoned when reset asserts.
  logic              dbg_we, mem_we;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  assign dbg_we    = (state == DWR) & ~reset;
  assign mem_we    = dbg_we | cpu_wr;
  assign mem_waddr = dbg_we ? MonAReg : avs_address;
  assign mem_wdata = dbg_we ? wdata_q : avs_writedata;
  assign mem_be    = dbg_we ? 4'hF : avs_byteenable;

  // Read address. When idle the port looks at the CPU address, so CRD finds
  // its data ready. In DVR1 MonAReg has already been incremented, so the
  // read-back targets the previous address.
  always_comb begin
    mem_raddr = MonAReg;
    if (idle)                mem_raddr = avs_address;
    else if (state == DVR1)  mem_raddr = MonAReg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    ram_q <= mem[mem_raddr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      MonAReg       <= '0;
      MonDReg       <= 32'h0;
      wdata_q       <= 32'h0;
      monitor_ready <= INIT_READY;
      monitor_error <= 1'b0;
    end else begin
      // A collision with a busy FSM drops the command and leaves the state as it is.
      if (!idle && any_strobe) monitor_error <= 1'b1;

      case (state)
        IDLE: begin
          if (take_action_ocimem_b) begin
            wdata_q       <= j_wdata;
            monitor_ready <= 1'b0;
            state         <= DWR;
          end else if (take_action_ocimem_a) begin
            MonAReg <= j_addr;
            if (j_clr_err) monitor_error <= 1'b0;
            if (j_rd_now) begin
              monitor_ready <= 1'b0;
              state         <= DRD1;
            end
          end else if (take_no_action_ocimem_a) begin
            MonAReg       <= MonAReg + 1'b1;
            monitor_ready <= 1'b0;
            state         <= DRD1;
          end else if (cpu_rd) begin
            state <= CRD;
          end
        end
        DRD1: state <= DRD2;          // ram_q <= mem[MonAReg] on this edge
        DRD2: begin
          MonDReg       <= ram_q;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
        DWR: begin
          MonDReg <= wdata_q;
          MonAReg <= MonAReg + 1'b1;
`ifdef OCIMEM_WRITE_VERIFY_EN
          state   <= DVR1;
`else
          monitor_ready <= 1'b1;
          state         <= IDLE;
`endif
        end
`ifdef OCIMEM_WRITE_VERIFY_EN
        DVR1: state <= DVR2;
        DVR2: begin
          if (ram_q != MonDReg) monitor_error <= 1'b1;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
`endif
        CRD:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
